// File: rtl/morse_pkg.sv
// Shared types and the A..H letter table for the Morse receive and display paths.
package morse_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPress,
    StGap,
    StEmit,
    StErr,
    StWaitRel
  } state_e;

  localparam logic SymDot  = 1'b0;
  localparam logic SymDash = 1'b1;

  localparam int unsigned NumLetters = 8;

  // Index 0 = A ... 7 = H. Symbol bit0 is the first symbol sent.
  localparam logic [2:0] LetterSize [NumLetters] = '{
    3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd4
  };
  localparam logic [3:0] LetterSym [NumLetters] = '{
    4'b0010, 4'b0001, 4'b0101, 4'b0001, 4'b0000, 4'b0100, 4'b0011, 4'b0000
  };

endpackage

// File: rtl/morse_key_decoder_if.sv
// Key/tick inputs and letter outputs of the Morse key decoder.
interface morse_key_decoder_if;
  logic       tick_in;
  logic       key_n;
  logic       letter_valid;
  logic [2:0] size_out;
  logic [3:0] sym_out;
  logic [2:0] code_out;
  logic       code_hit;
  logic       err_out;
  logic       busy_out;

  // Decoder side.
  modport master (
    input  tick_in, key_n,
    output letter_valid, size_out, sym_out, code_out, code_hit, err_out, busy_out
  );

  // Stimulus / consumer side.
  modport slave (
    output tick_in, key_n,
    input  letter_valid, size_out, sym_out, code_out, code_hit, err_out, busy_out
  );
endinterface

// File: rtl/morse_letter_lookup.sv
// Combinational match of a size/symbol pair against the A..H table.
module morse_letter_lookup
  import morse_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [3:0] sym_i,
  output logic [2:0] code_o,
  output logic       hit_o
);

  // Table entries are unique, so at most one index matches.
  always_comb begin
    code_o = '0;
    hit_o  = 1'b0;
    for (int unsigned i = 0; i < NumLetters; i++) begin
      if (size_i == LetterSize[i] && sym_i == LetterSym[i]) begin
        code_o = 3'(i);
        hit_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_key_decoder.sv
// Times key presses in half-second ticks, builds up to four dot/dash symbols and
// emits the letter after a silent gap.
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int unsigned DOT_MAX_TICKS    = 2,
  parameter int unsigned DASH_MAX_TICKS   = 6,
  parameter int unsigned LETTER_GAP_TICKS = 3
) (
  input logic               clk,
  input logic               reset,
  morse_key_decoder_if.master bus
);

  localparam logic [2:0] DotMax  = 3'(DOT_MAX_TICKS);
  localparam logic [2:0] DashMax = 3'(DASH_MAX_TICKS);
  localparam logic [2:0] GapMax  = 3'(LETTER_GAP_TICKS);

  state_e     state_q, state_d;
  logic       key_meta_q, key_sync_q;
  logic [2:0] press_cnt_q, press_cnt_d;
  logic [2:0] sym_cnt_q, sym_cnt_d;
  logic [3:0] shreg_q, shreg_d;
  logic [2:0] gap_cnt_q, gap_cnt_d;
  logic [2:0] size_q, code_q;
  logic [3:0] sym_q;
  logic       hit_q;
  logic       load_letter;
  logic       pressed;
  logic [2:0] lk_code;
  logic       lk_hit;

  assign pressed = ~key_sync_q;

  morse_letter_lookup u_lookup (
    .size_i (sym_cnt_q),
    .sym_i  (shreg_q),
    .code_o (lk_code),
    .hit_o  (lk_hit)
  );

  // Two-flop synchronizer for the asynchronous key.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_meta_q <= 1'b0;
      key_sync_q <= 1'b0;
    end else begin
      key_meta_q <= bus.key_n;
      key_sync_q <= key_meta_q;
    end
  end

  // State and symbol-collection registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      press_cnt_q <= '0;
      sym_cnt_q   <= '0;
      shreg_q     <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      press_cnt_q <= press_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      shreg_q     <= shreg_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  // Next-state logic: press timing, symbol recording and letter closing.
  always_comb begin
    state_d     = state_q;
    press_cnt_d = press_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    shreg_d     = shreg_q;
    gap_cnt_d   = gap_cnt_q;
    load_letter = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pressed) begin
          state_d     = StPress;
          press_cnt_d = '0;
          sym_cnt_d   = '0;
          shreg_d     = '0;
        end
      end
      StPress: begin
        // Release takes priority over a coincident tick.
        if (!pressed) begin
          if (press_cnt_q == 3'd0) begin
            state_d = (sym_cnt_q != 3'd0) ? StGap : StIdle;
          end else if (press_cnt_q > DashMax || sym_cnt_q == 3'd4) begin
            state_d = StErr;
          end else begin
            shreg_d[sym_cnt_q[1:0]] = (press_cnt_q > DotMax) ? SymDash : SymDot;
            sym_cnt_d = sym_cnt_q + 3'd1;
            gap_cnt_d = '0;
            state_d   = StGap;
          end
        end else if (bus.tick_in && press_cnt_q != 3'd7) begin
          press_cnt_d = press_cnt_q + 3'd1;
        end
      end
      StGap: begin
        // A new press takes priority over a coincident tick.
        if (pressed) begin
          state_d     = StPress;
          press_cnt_d = '0;
        end else if (bus.tick_in) begin
          gap_cnt_d = gap_cnt_q + 3'd1;
          if (gap_cnt_q + 3'd1 == GapMax) begin
            state_d     = StEmit;
            load_letter = 1'b1;
          end
        end
      end
      StEmit:    state_d = StIdle;
      StErr:     state_d = StWaitRel;
      StWaitRel: if (!pressed) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Letter outputs load on entry to EMIT so they are valid alongside the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      size_q <= '0;
      sym_q  <= '0;
      code_q <= '0;
      hit_q  <= 1'b0;
    end else if (load_letter) begin
      size_q <= sym_cnt_q;
      sym_q  <= shreg_q;
      code_q <= lk_code;
      hit_q  <= lk_hit;
    end
  end

  assign bus.letter_valid = (state_q == StEmit);
  assign bus.err_out      = (state_q == StErr);
  assign bus.busy_out     = (state_q != StIdle);
  assign bus.size_out     = size_q;
  assign bus.sym_out      = sym_q;
  assign bus.code_out     = code_q;
  assign bus.code_hit     = hit_q;

endmodule
